// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with open-drain clk/data drive.
// Optional PS2_HOST_TX_RETRY_EN retries a failed frame up to two more times before tx_error.
module ps2_host_tx #(
    parameter int CLK_FREQ   = 25000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000,
    parameter int FILTER     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out
);
    localparam int unsigned INH_N = (INHIBIT_US * (CLK_FREQ / 1000)) / 1000;
    localparam int unsigned TO_N  = (TIMEOUT_US * (CLK_FREQ / 1000)) / 1000;
    localparam int IW = $clog2(INH_N + 1);
    localparam int TW = $clog2(TO_N + 1);
    localparam int FW = $clog2(FILTER + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, ERR} state_t;

    state_t        state;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s, clk_f, fall;
    logic [FW-1:0] fcnt;
    logic [7:0]    byte_q;
    logic          parity;
    logic [3:0]    idx;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic          timing, timeout, nack, fail;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]    tries;
`endif

    assign clk_s = clk_sync[1];
    assign data_s = data_sync[1];

    // The filtered clock only follows the synchronized input after FILTER consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            data_sync <= 2'b11;
            clk_f <= 1'b1;
            fcnt <= '0;
            fall <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            fall <= 1'b0;
            if (clk_s == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER - 1)) begin
                clk_f <= clk_s;
                fcnt <= '0;
                fall <= clk_f;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign timing = state inside {RTS, SHIFT, ACK, WAIT_IDLE};
    assign timeout = timing && (tcnt == TW'(TO_N - 1));
    assign nack = (state == ACK) && fall && data_s;
    assign fail = timeout || nack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ps2_clk_out <= 1'b1;
            ps2_data_out <= 1'b1;
            tx_ready <= 1'b1;
            busy <= 1'b0;
            tx_done <= 1'b0;
            tx_error <= 1'b0;
            byte_q <= '0;
            parity <= 1'b0;
            idx <= '0;
            icnt <= '0;
            tcnt <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
            tries <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_error <= 1'b0;
            if (timing && !timeout) tcnt <= tcnt + 1'b1;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state <= INHIBIT;
                        byte_q <= tx_data;
                        parity <= ~^tx_data;
                        tx_ready <= 1'b0;
                        busy <= 1'b1;
                        ps2_clk_out <= 1'b0;
                        icnt <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
                        tries <= '0;
`endif
                    end else begin
                        tx_ready <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (icnt == IW'(INH_N - 1)) begin
                        state <= RTS;
                        ps2_data_out <= 1'b0;
                        tcnt <= '0;
                    end else begin
                        icnt <= icnt + 1'b1;
                    end
                end
                RTS: begin
                    ps2_clk_out <= 1'b1;
                    idx <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (fall) begin
                        idx <= idx + 1'b1;
                        ps2_data_out <= (idx < 4'd8) ? byte_q[idx[2:0]] : (idx == 4'd8) ? parity : 1'b1;
                        if (idx == 4'd9) state <= ACK;
                    end
                end
                ACK: if (fall && !data_s) state <= WAIT_IDLE;
                WAIT_IDLE: begin
                    if (clk_f && data_s) begin
                        state <= IDLE;
                        tx_done <= 1'b1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                    tx_ready <= 1'b1;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // A failure overrides whatever the state step above decided.
            if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
                if (tries != 2'd2) begin
                    tries <= tries + 1'b1;
                    state <= INHIBIT;
                    ps2_clk_out <= 1'b0;
                    ps2_data_out <= 1'b1;
                    icnt <= '0;
                end else
`endif
                begin
                    state <= ERR;
                    ps2_clk_out <= 1'b1;
                    ps2_data_out <= 1'b1;
                    tx_error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device and checks frames, timing and pulses.
module tb_ps2_host_tx;
    localparam int INH = 2500;
    localparam int TO = 10000;
    localparam int H = 60;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0;
    logic tx_ready, tx_done, tx_error, busy, ps2_clk_out, ps2_data_out;
    logic ps2_clk_in, ps2_data_in;
    logic dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;

    assign ps2_clk_in = ps2_clk_out & dev_clk & ~glitch;
    assign ps2_data_in = ps2_data_out & dev_data;

    always #20 clk = ~clk;

    ps2_host_tx #(.CLK_FREQ(25000000), .INHIBIT_US(100), .TIMEOUT_US(400), .FILTER(8)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out)
    );

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_done = 0, n_err = 0, n_inh = 0, viol = 0;
    int clk_low = 0, last_clk_low = 0, inh_len = 0, last_inh = 0, rts_cyc = 0, err_cyc = 0;
    logic prev_clk = 1'b1, prev_data = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (tx_done === 1'b1) n_done++;
        if (tx_error === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
        if ((tx_done && tx_error) || (tx_ready && (tx_done || tx_error || busy))) viol++;
        if (!ps2_clk_out && prev_clk) begin
            n_inh++;
            clk_low = 0;
            inh_len = 0;
        end
        if (!ps2_clk_out) clk_low++;
        if (ps2_clk_out && !prev_clk) last_clk_low = clk_low;
        if (!ps2_clk_out && ps2_data_out) inh_len++;
        if (!ps2_data_out && prev_data) begin
            rts_cyc = cyc;
            last_inh = inh_len;
        end
        prev_clk = ps2_clk_out;
        prev_data = ps2_data_out;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected device view: 8 data bits LSB first, odd parity, stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic send(input logic [7:0] b);
        int k = 0;
        while (tx_ready !== 1'b1 && k < 1000) begin
            step(1);
            k++;
        end
        check("ready_wait", 32'(tx_ready), 1);
        tx_data = b;
        tx_valid = 1'b1;
        step(1);
        tx_data = ~b;
        step(5);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic device(input bit do_clock, input bit ack, input bit glitchy, input int pulses,
                          output logic [9:0] got);
        int i = 0;
        got = '0;
        while (!(ps2_clk_out === 1'b1 && ps2_data_out === 1'b0) && i < 20000) begin
            step(1);
            i++;
        end
        check("rts_seen", 32'(ps2_clk_out === 1'b1 && ps2_data_out === 1'b0), 1);
        if (!do_clock) return;
        step(H);
        for (int n = 0; n < pulses; n++) begin
            if (n == 10) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            step(H);
            if (n < 10) got[n] = ps2_data_in;
            dev_clk = 1'b1;
            if (n == 10) dev_data = 1'b1;
            if (glitchy && n < 10) begin
                step(20);
                glitch = 1'b1;
                step(4);
                glitch = 1'b0;
                step(H - 24);
            end else begin
                step(H);
            end
        end
    endtask

    task automatic good_frame(input logic [7:0] b, input bit glitchy, input string tag);
        logic [9:0] got;
        int d0, e0, k;
        d0 = n_done;
        e0 = n_err;
        send(b);
        device(1'b1, 1'b1, glitchy, 11, got);
        k = 0;
        while (n_done == d0 && k < 500) begin
            step(1);
            k++;
        end
        check({tag, "_bits"}, 32'(got), 32'(frame_of(b)));
        check({tag, "_done"}, n_done - d0, 1);
        check({tag, "_noerr"}, n_err - e0, 0);
        check({tag, "_inhibit"}, last_inh, INH);
        check({tag, "_released"}, {30'd0, ps2_clk_out, ps2_data_out}, 3);
        step(1);
        check({tag, "_ready"}, 32'(tx_ready), 1);
    endtask

    task automatic fail_frame(input bit clocked, input string tag);
        logic [9:0] got;
        logic [7:0] b;
        int d0, e0, i0, k;
        b = 8'($urandom);
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh;
        send(b);
        repeat (ATTEMPTS) device(clocked, 1'b0, 1'b0, 11, got);
        k = 0;
        while (n_err == e0 && k < TO + 500) begin
            step(1);
            k++;
        end
        if (clocked) check({tag, "_bits"}, 32'(got), 32'(frame_of(b)));
        else check({tag, "_latency"}, err_cyc - rts_cyc, TO);
        check({tag, "_err"}, n_err - e0, 1);
        check({tag, "_nodone"}, n_done - d0, 0);
        check({tag, "_attempts"}, n_inh - i0, ATTEMPTS);
        check({tag, "_released"}, {30'd0, ps2_clk_out, ps2_data_out}, 3);
        step(1);
        check({tag, "_ready"}, 32'(tx_ready), 1);
    endtask

    initial begin
        logic [9:0] got;
        int d0, e0;
        step(3);
        check("rst_clk", 32'(ps2_clk_out), 1);
        check("rst_data", 32'(ps2_data_out), 1);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_err", 32'(tx_error), 0);
        reset = 1'b0;
        step(2);

        good_frame(8'hED, 1'b0, "ed");
        check("ed_clk_low", last_clk_low, INH + 1);
        good_frame(8'hF4, 1'b0, "f4");
        repeat (2) good_frame(8'($urandom), 1'b0, "rnd");
        good_frame(8'($urandom), 1'b1, "glitch");

        fail_frame(1'b1, "nack");
        fail_frame(1'b0, "timeout");

        d0 = n_done;
        e0 = n_err;
        send(8'hA5);
        device(1'b1, 1'b1, 1'b0, 4, got);
        check("mid_bits", 32'(got[3:0]), 32'h5);
        check("mid_data_low", 32'(ps2_data_out), 0);
        reset = 1'b1;
        step(1);
        check("mid_rst_lines", {30'd0, ps2_clk_out, ps2_data_out}, 3);
        reset = 1'b0;
        step(50);
        check("mid_rst_nodone", n_done - d0, 0);
        check("mid_rst_noerr", n_err - e0, 0);
        check("mid_rst_ready", 32'(tx_ready), 1);
        good_frame(8'h55, 1'b0, "post_rst");

        check("pulse_rules", viol, 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes from the core, such as keyboard LED set (0xED) or mouse enable (0xF4), back over the emulated PS/2 keyboard and mouse links. It is the opposite direction to the existing device-to-host receive path. One instance sits in cadr_core per link, driving ps2_*_clk_out and ps2_*_data_out as open-drain: 1 = release, 0 = pull low.

Parameters:
CLK_FREQ, 25000000, clk frequency in Hz; used to derive all timing counts.
INHIBIT_US, 100, time the host holds PS/2 clock low before the request-to-send.
TIMEOUT_US, 15000, maximum time from clock release to final ACK/idle before aborting.
FILTER, 8, consecutive stable samples required to accept a level change on the filtered ps2 clk.

Ports:
clk  in  1  core clock; all logic on the rising edge.
reset  in  1  synchronous, active-high.
tx_data  in  8  byte to send.
tx_valid  in  1  request; byte accepted when tx_valid & tx_ready.
tx_ready  out  1  high only in IDLE.
tx_done  out  1  one-cycle pulse; the device ACKed and the bus has returned to idle.
tx_error  out  1  one-cycle pulse on timeout or missing ACK.
busy  out  1  high in every state except IDLE.
ps2_clk_in  in  1  device clock level (asynchronous).
ps2_data_in  in  1  device data level (asynchronous).
ps2_clk_out  out  1  host clock drive; 0 = pull low.
ps2_data_out  out  1  host data drive; 0 = pull low.

Behaviour:
- Reset values: ps2_clk_out=1, ps2_data_out=1, tx_ready=1 (IDLE), tx_done=0, tx_error=0, busy=0. Reset mid-frame releases both lines on the next edge and aborts silently, with no pulse.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer. The clock then goes through the FILTER-sample stable filter. A falling edge is a filtered 1->0 transition.
- On acceptance, latch tx_data and compute parity = ~^tx_data (odd parity).
- IDLE: both lines released. On accept, go to INHIBIT.
- INHIBIT: clk_out=0, data_out=1 for INHIBIT_US*CLK_FREQ/1e6 cycles, then go to RTS.
- RTS: data_out=0 (start bit), then one cycle later clk_out=1. The timeout counter starts here. Go to SHIFT with bit index 0.
- SHIFT: on each filtered falling edge, index k=0..7 drives data_out=byte[k] (LSB first). Index 8 drives parity. Index 9 sets data_out=1 (stop bit / release). Then go to ACK.
- ACK: on the next falling edge, sample synchronized data. 0 → go to WAIT_IDLE. 1 → go to ERR.
- WAIT_IDLE: wait until filtered clk=1 and data=1, then pulse tx_done and go to IDLE.
- ERR: release both lines, pulse tx_error and go to IDLE.
- Timeout: if the counter reaches TIMEOUT_US*CLK_FREQ/1e6 in RTS, SHIFT, ACK or WAIT_IDLE, go to ERR from any of those states.
- tx_done and tx_error are mutually exclusive and never asserted in the same cycle as tx_ready.
- tx_valid while busy is ignored. There is no queuing; tx_data is not re-sampled.
- A glitch shorter than FILTER cycles on ps2_clk_in never advances the bit index.
- Back-to-back sends: tx_ready reasserts the cycle after the done or error pulse.
- Counter widths are sized by $clog2 of the derived counts. All counts saturate; none wraps.

Optional Feature:
PS2_HOST_TX_RETRY_EN
- Defined: a missing ACK or a timeout re-enters INHIBIT with the same latched byte, up to 2 retries (3 attempts total). tx_error pulses only after the third failure. busy stays high across retries. tx_done pulses once, on eventual success.
- Undefined: the first failure goes directly to ERR. There is no retry logic or counter.

Test Plan:
- Send 0xED with a device model that clocks at 12 kHz and ACKs. Required: clk_out low for 2500 cycles at 25 MHz; bits 1,0,1,1,0,1,1,1 LSB-first; parity 1; tx_done pulses once; lines released.
- Send 0xF4. Required: parity bit 0 (five ones → odd parity = 0); device-sampled byte equals 0xF4.
- Device model never clocks after RTS. Required: tx_error at exactly 375000 cycles after RTS; both outputs return to 1; tx_ready=1 the following cycle.
- Device leaves data high at the ACK edge. Required: tx_error pulse, no tx_done. With PS2_HOST_TX_RETRY_EN defined: 3 INHIBIT phases, then a single tx_error.
- Inject 4-cycle low glitches on ps2_clk_in during SHIFT. Required: bit index unchanged; byte received correctly; tx_done pulses.
- Assert reset in SHIFT after bit 3. Required: clk_out=data_out=1 next cycle; no done or error pulse; then a fresh 0x55 send completes normally.
